// File: rtl/mod_n_unit_counter.sv
// mod_n_unit_counter
//
// Counts pulse_en steps modulo MODULUS. The mode input selects wrap-up,
// wrap-down, one-shot countdown or hold at run time. Instances cascade by
// feeding overflow_flag of one stage into pulse_en of the next stage, for
// example seconds -> minutes -> hours, or a multi-stage countdown timer.
//
// Parameters:
//   WIDTH    counter width in bits
//   MODULUS  count range 0..MODULUS-1, legal for 2 <= MODULUS <= 2**WIDTH
//
// Ports:
//   m_clk          system clock, rising edge
//   a_rst          synchronous active-high reset
//   pulse_en       count-step enable, one step per cycle while high
//   mode           0 wrap-up, 1 wrap-down, 2 one-shot down, 3 hold
//   clr            synchronous clear to 0
//   load           synchronous load of load_val, clamped to MODULUS-1
//   load_val       preset value
//   match_val      compare value
//   q_val          current count, registered
//   overflow_flag  combinational terminal-step strobe (carry/borrow)
//   match_flag     registered one-cycle pulse after a step lands on match_val
//   done           registered sticky one-shot completion flag
//   load_err       registered one-cycle pulse after an out-of-range load
//
// Priority on each edge: a_rst > clr > load > count step.

module mod_n_unit_counter #(
  parameter int WIDTH   = 6,
  parameter int MODULUS = 60
) (
  input  logic             m_clk,
  input  logic             a_rst,
  input  logic             pulse_en,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] match_val,
  output logic [WIDTH-1:0] q_val,
  output logic             overflow_flag,
  output logic             match_flag,
  output logic             done,
  output logic             load_err
);

  typedef enum logic [1:0] {
    MODE_UP      = 2'd0,
    MODE_DOWN    = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_e;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  // Refuse to elaborate with a modulus the counter cannot represent.
  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("mod_n_unit_counter: MODULUS must be in 2..2**WIDTH");
  end

  mode_e            cur_mode;
  logic             step_req;
  logic             step_taken;
  logic             wrap_hit;
  logic             match_hit;
  logic             done_set;
  logic [WIDTH-1:0] next_val;

  assign cur_mode = mode_e'(mode);

  // A step can only happen when nothing of higher priority claims the edge.
  assign step_req = pulse_en && !a_rst && !clr && !load;

  // Next count value and terminal-step detection. Wrapping uses explicit
  // compares so a non-power-of-two modulus never relies on natural overflow.
  always_comb begin
    next_val   = q_val;
    step_taken = 1'b0;
    wrap_hit   = 1'b0;
    if (step_req) begin
      case (cur_mode)
        MODE_UP: begin
          step_taken = 1'b1;
          if (q_val == MAX_VAL) begin
            next_val = ZERO;
            wrap_hit = 1'b1;
          end else begin
            next_val = q_val + ONE;
          end
        end
        MODE_DOWN: begin
          step_taken = 1'b1;
          if (q_val == ZERO) begin
            next_val = MAX_VAL;
            wrap_hit = 1'b1;
          end else begin
            next_val = q_val - ONE;
          end
        end
        MODE_ONESHOT: begin
          // Once finished, or already at zero, further pulses are ignored.
          if (!done && q_val != ZERO) begin
            step_taken = 1'b1;
            next_val   = q_val - ONE;
            wrap_hit   = (q_val == ONE);
          end
        end
        default: begin
          next_val = q_val;
        end
      endcase
    end
  end

  assign overflow_flag = wrap_hit;

  // An out-of-range compare value can never be reached, so it never matches.
  assign match_hit = step_taken && (next_val == match_val) && (match_val <= MAX_VAL);
  assign done_set  = step_taken && (cur_mode == MODE_ONESHOT) && (next_val == ZERO);

  // State register. match_flag and load_err are single-cycle pulses, so every
  // branch that does not explicitly raise them drops them back to 0.
  always_ff @(posedge m_clk) begin
    if (a_rst) begin
      q_val      <= ZERO;
      match_flag <= 1'b0;
      done       <= 1'b0;
      load_err   <= 1'b0;
    end else if (clr) begin
      q_val      <= ZERO;
      match_flag <= 1'b0;
      done       <= 1'b0;
      load_err   <= 1'b0;
    end else if (load) begin
      match_flag <= 1'b0;
      done       <= 1'b0;
      if (load_val <= MAX_VAL) begin
        q_val    <= load_val;
        load_err <= 1'b0;
      end else begin
        q_val    <= MAX_VAL;
        load_err <= 1'b1;
      end
    end else begin
      load_err   <= 1'b0;
      match_flag <= match_hit;
      if (step_taken) begin
        q_val <= next_val;
      end
      if (done_set) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_n_unit_counter.sv
// tb_mod_n_unit_counter
//
// Self-checking bench for mod_n_unit_counter. The main instance uses the
// default WIDTH=6 / MODULUS=60; a second instance uses WIDTH=4 / MODULUS=10
// to exercise wrap-down with a non-power-of-two modulus.
//
// For the main instance an integer reference model predicts each cycle's
// results; the prediction is pushed to a scoreboard queue when the stimulus
// is driven and popped once the DUT outputs for that cycle are sampled.

module tb_mod_n_unit_counter;

  localparam int MOD = 60;

  logic m_clk = 1'b0;
  always #5 m_clk = ~m_clk;

  // Main instance signals
  logic       a_rst;
  logic       pulse_en;
  logic [1:0] mode;
  logic       clr;
  logic       load;
  logic [5:0] load_val;
  logic [5:0] match_val;
  logic [5:0] q_val;
  logic       overflow_flag;
  logic       match_flag;
  logic       done;
  logic       load_err;

  // Second instance signals
  logic       b_rst;
  logic       b_pe;
  logic [1:0] b_mode;
  logic       b_clr;
  logic       b_load;
  logic [3:0] b_lv;
  logic [3:0] b_mv;
  logic [3:0] b_q;
  logic       b_ovf;
  logic       b_match;
  logic       b_done;
  logic       b_lerr;

  mod_n_unit_counter #(.WIDTH(6), .MODULUS(60)) dut (
    .m_clk         (m_clk),
    .a_rst         (a_rst),
    .pulse_en      (pulse_en),
    .mode          (mode),
    .clr           (clr),
    .load          (load),
    .load_val      (load_val),
    .match_val     (match_val),
    .q_val         (q_val),
    .overflow_flag (overflow_flag),
    .match_flag    (match_flag),
    .done          (done),
    .load_err      (load_err)
  );

  mod_n_unit_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .m_clk         (m_clk),
    .a_rst         (b_rst),
    .pulse_en      (b_pe),
    .mode          (b_mode),
    .clr           (b_clr),
    .load          (b_load),
    .load_val      (b_lv),
    .match_val     (b_mv),
    .q_val         (b_q),
    .overflow_flag (b_ovf),
    .match_flag    (b_match),
    .done          (b_done),
    .load_err      (b_lerr)
  );

  // ovf is the combinational strobe of the cycle; the rest is the state
  // expected after the edge that closes the cycle.
  typedef struct {
    int q;
    bit ovf;
    bit match;
    bit done;
    bit lerr;
  } exp_t;

  exp_t       cur;
  exp_t       want;
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [5:0] obs_q;
  logic [3:0] obs_flags;

  // Reference model of one clock cycle, written with integer modulo math.
  function automatic exp_t model(input exp_t s, input bit rst, input bit c,
                                 input bit l, input int lv, input bit pe,
                                 input int md, input int mv);
    exp_t n;
    int   nq;
    bit   stepped;
    n       = s;
    n.ovf   = 1'b0;
    n.match = 1'b0;
    n.lerr  = 1'b0;
    nq      = s.q;
    stepped = 1'b0;
    if (rst || c) begin
      n.q    = 0;
      n.done = 1'b0;
    end else if (l) begin
      n.done = 1'b0;
      if (lv < MOD) begin
        n.q = lv;
      end else begin
        n.q    = MOD - 1;
        n.lerr = 1'b1;
      end
    end else if (pe) begin
      case (md)
        0: begin
          nq      = (s.q + 1) % MOD;
          stepped = 1'b1;
          n.ovf   = (s.q == MOD - 1);
        end
        1: begin
          nq      = (s.q + MOD - 1) % MOD;
          stepped = 1'b1;
          n.ovf   = (s.q == 0);
        end
        2: begin
          if (!s.done && s.q > 0) begin
            nq      = s.q - 1;
            stepped = 1'b1;
            n.ovf   = (nq == 0);
            if (nq == 0) n.done = 1'b1;
          end
        end
        default: stepped = 1'b0;
      endcase
      if (stepped) begin
        n.q     = nq;
        n.match = (nq == mv);
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] pack_flags(input exp_t e);
    return {e.ovf, e.match, e.done, e.lerr};
  endfunction

  // Drive one cycle of the main instance with the inputs already set:
  // predict, push the prediction, sample the strobe mid-cycle and the
  // registered outputs just after the edge.
  task automatic run_cycle();
    exp_t nxt;
    nxt = model(cur, a_rst, clr, load, int'(load_val), pulse_en,
                int'(mode), int'(match_val));
    sb.push_back(nxt);
    #1;
    obs_flags[3] = overflow_flag;
    @(posedge m_clk);
    #1;
    obs_q          = q_val;
    obs_flags[2:0] = {match_flag, done, load_err};
    cur = nxt;
  endtask

  task automatic set_idle();
    a_rst    = 1'b0;
    pulse_en = 1'b0;
    clr      = 1'b0;
    load     = 1'b0;
  endtask

  task automatic test_reset();
    a_rst    = 1'b1;
    pulse_en = 1'b1;
    mode     = 2'd0;
    run_cycle();
    want = sb.pop_front();
    checks++;
    if (obs_q !== 6'(want.q) || obs_flags !== pack_flags(want)) begin
      errors++;
      $display("[TB] FAIL reset: got q=%0d flags(ovf,match,done,lerr)=%b want q=%0d flags=%b",
               obs_q, obs_flags, want.q, pack_flags(want));
    end
    checks++;
    if (obs_q !== 6'd0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_const: got q=%0d done=%b want q=0 done=0", obs_q, done);
    end
    set_idle();
  endtask

  task automatic test_wrap_up();
    int ovf_count;
    ovf_count = 0;
    mode      = 2'd0;
    match_val = 6'd30;
    for (int i = 1; i <= 60; i++) begin
      pulse_en = 1'b1;
      run_cycle();
      want = sb.pop_front();
      if (obs_flags[3] === 1'b1) ovf_count++;
      checks++;
      if (obs_q !== 6'(want.q) || obs_flags !== pack_flags(want)) begin
        errors++;
        $display("[TB] FAIL wrap_up step %0d: got q=%0d flags=%b want q=%0d flags=%b",
                 i, obs_q, obs_flags, want.q, pack_flags(want));
      end
    end
    set_idle();
    checks++;
    if (ovf_count !== 1 || obs_q !== 6'd0) begin
      errors++;
      $display("[TB] FAIL wrap_up_total: got overflows=%0d q=%0d want overflows=1 q=0",
               ovf_count, obs_q);
    end
  endtask

  task automatic test_wrap_down();
    logic want_ovf;
    b_rst  = 1'b1;
    b_pe   = 1'b0;
    b_mode = 2'd1;
    @(posedge m_clk);
    #1;
    b_rst = 1'b0;
    checks++;
    if (b_q !== 4'd0) begin
      errors++;
      $display("[TB] FAIL wrap_down_reset: got q=%0d want 0", b_q);
    end
    for (int i = 1; i <= 10; i++) begin
      b_pe     = 1'b1;
      want_ovf = (i == 1);
      #1;
      checks++;
      if (b_ovf !== want_ovf) begin
        errors++;
        $display("[TB] FAIL wrap_down_ovf step %0d: got %b want %b", i, b_ovf, want_ovf);
      end
      @(posedge m_clk);
      #1;
      checks++;
      if (b_q !== 4'((10 - i) % 10)) begin
        errors++;
        $display("[TB] FAIL wrap_down_q step %0d: got %0d want %0d", i, b_q, (10 - i) % 10);
      end
    end
    b_pe = 1'b0;
  endtask

  task automatic test_one_shot();
    match_val = 6'd63;
    mode      = 2'd2;
    load      = 1'b1;
    load_val  = 6'd3;
    for (int i = 0; i <= 6; i++) begin
      if (i >= 1 && i <= 5) begin
        load     = 1'b0;
        pulse_en = 1'b1;
      end else if (i == 6) begin
        pulse_en = 1'b0;
        clr      = 1'b1;
      end
      run_cycle();
      want = sb.pop_front();
      checks++;
      if (obs_q !== 6'(want.q) || obs_flags !== pack_flags(want)) begin
        errors++;
        $display("[TB] FAIL one_shot step %0d: got q=%0d flags=%b want q=%0d flags=%b",
                 i, obs_q, obs_flags, want.q, pack_flags(want));
      end
      if (i == 5) begin
        checks++;
        if (obs_q !== 6'd0 || done !== 1'b1) begin
          errors++;
          $display("[TB] FAIL one_shot_done: got q=%0d done=%b want q=0 done=1", obs_q, done);
        end
      end
    end
    set_idle();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL one_shot_clr: got done=%b want 0", done);
    end
  endtask

  task automatic test_priority();
    mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      set_idle();
      case (i)
        0: begin load = 1'b1; load_val = 6'd59; end
        1: begin clr = 1'b1; load = 1'b1; load_val = 6'd7; pulse_en = 1'b1; end
        default: begin load = 1'b1; load_val = 6'd7; pulse_en = 1'b1; end
      endcase
      run_cycle();
      want = sb.pop_front();
      checks++;
      if (obs_q !== 6'(want.q) || obs_flags !== pack_flags(want)) begin
        errors++;
        $display("[TB] FAIL priority step %0d: got q=%0d flags=%b want q=%0d flags=%b",
                 i, obs_q, obs_flags, want.q, pack_flags(want));
      end
      if (i == 1) begin
        checks++;
        if (obs_q !== 6'd0 || obs_flags[3] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL priority_clr: got q=%0d ovf=%b want q=0 ovf=0", obs_q, obs_flags[3]);
        end
      end
    end
    set_idle();
    checks++;
    if (q_val !== 6'd7) begin
      errors++;
      $display("[TB] FAIL priority_load: got q=%0d want 7", q_val);
    end
  endtask

  task automatic test_bad_load_match();
    mode      = 2'd0;
    match_val = 6'd5;
    for (int i = 0; i < 7; i++) begin
      set_idle();
      case (i)
        0: begin load = 1'b1; load_val = 6'd63; end
        2: begin load = 1'b1; load_val = 6'd4; end
        3: pulse_en = 1'b1;
        5: begin load = 1'b1; load_val = 6'd5; end
        default: pulse_en = 1'b0;
      endcase
      run_cycle();
      want = sb.pop_front();
      checks++;
      if (obs_q !== 6'(want.q) || obs_flags !== pack_flags(want)) begin
        errors++;
        $display("[TB] FAIL bad_load_match step %0d: got q=%0d flags=%b want q=%0d flags=%b",
                 i, obs_q, obs_flags, want.q, pack_flags(want));
      end
      if (i == 0) begin
        checks++;
        if (obs_q !== 6'd59 || load_err !== 1'b1) begin
          errors++;
          $display("[TB] FAIL clamp: got q=%0d load_err=%b want q=59 load_err=1", obs_q, load_err);
        end
      end
      if (i == 3) begin
        checks++;
        if (obs_q !== 6'd5 || match_flag !== 1'b1) begin
          errors++;
          $display("[TB] FAIL match_pulse: got q=%0d match=%b want q=5 match=1", obs_q, match_flag);
        end
      end
    end
    set_idle();
  endtask

  task automatic test_reset_hold();
    int ovf_seen;
    ovf_seen  = 0;
    match_val = 6'd63;
    for (int i = 0; i < 16; i++) begin
      set_idle();
      case (i)
        0: begin mode = 2'd2; load = 1'b1; load_val = 6'd1; end
        1: begin mode = 2'd2; pulse_en = 1'b1; end
        2: begin mode = 2'd0; pulse_en = 1'b1; end
        3: begin mode = 2'd2; pulse_en = 1'b1; end
        4: begin mode = 2'd2; a_rst = 1'b1; pulse_en = 1'b1; end
        5: begin load = 1'b1; load_val = 6'd12; end
        default: begin mode = 2'd3; pulse_en = 1'b1; end
      endcase
      run_cycle();
      want = sb.pop_front();
      if (i >= 6 && obs_flags[3] === 1'b1) ovf_seen++;
      checks++;
      if (obs_q !== 6'(want.q) || obs_flags !== pack_flags(want)) begin
        errors++;
        $display("[TB] FAIL reset_hold step %0d: got q=%0d flags=%b want q=%0d flags=%b",
                 i, obs_q, obs_flags, want.q, pack_flags(want));
      end
      if (i == 4) begin
        checks++;
        if (obs_q !== 6'd0 || obs_flags[2:0] !== 3'b000) begin
          errors++;
          $display("[TB] FAIL mid_reset: got q=%0d match/done/lerr=%b want q=0 000",
                   obs_q, obs_flags[2:0]);
        end
      end
    end
    set_idle();
    checks++;
    if (q_val !== 6'd12 || ovf_seen !== 0) begin
      errors++;
      $display("[TB] FAIL hold: got q=%0d overflows=%0d want q=12 overflows=0", q_val, ovf_seen);
    end
  endtask

  // Safety net in case the run stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence.
  initial begin
    a_rst     = 1'b0;
    pulse_en  = 1'b0;
    mode      = 2'd0;
    clr       = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    match_val = 6'd63;
    b_rst     = 1'b1;
    b_pe      = 1'b0;
    b_mode    = 2'd1;
    b_clr     = 1'b0;
    b_load    = 1'b0;
    b_lv      = '0;
    b_mv      = 4'd15;
    cur       = '{q: 0, ovf: 1'b0, match: 1'b0, done: 1'b0, lerr: 1'b0};
    #2;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_one_shot();
    test_priority();
    test_bad_load_match();
    test_reset_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
